// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state and settings types for the pipeline reconfiguration sequencer
package pipe_ctrl_pkg;

    localparam int THRESH_W = 26;

    typedef enum logic [2:0] {
        CFG_START,
        CFG_WAIT,
        DISCARD,
        RUN,
        PENDING,
        FLUSH,
        APPLY
    } ctrl_state_t;

    // Operator settings as one bundle, so requests and applied values compare and load in one step
    typedef struct packed {
        logic                mode;
        logic                gaussian;
        logic                sobel;
        logic [THRESH_W-1:0] threshold;
    } pipe_settings_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with a done flag at zero
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pipe_reconfig_ctrl.sv
// rtl/pipe_reconfig_ctrl.sv - frame-synchronous bring-up and settings-change sequencer for the video pipeline
module pipe_reconfig_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          FLUSH_CYCLES   = 16,
    parameter int          DISCARD_FRAMES = 2,
    parameter int          SOF_TIMEOUT    = 2_500_000,
    parameter logic [25:0] THRESH_INIT    = 26'd4000
) (
    input  logic        i_sysclk,
    input  logic        i_rstn,
    input  logic        i_sof,
    input  logic        i_cfg_done,
    input  logic        i_freeze,
    input  logic        i_req_mode,
    input  logic        i_req_gaussian,
    input  logic        i_req_sobel,
    input  logic [25:0] i_req_threshold,
    output logic        o_cfg_start,
    output logic        o_mode,
    output logic        o_gaussian_enable,
    output logic        o_sobel_enable,
    output logic [25:0] o_sobel_threshold,
    output logic        o_pipe_flush,
    output logic        o_busy,
    output logic        o_sof_timeout
);

    localparam int             CNT_W        = $clog2(max_int(FLUSH_CYCLES, SOF_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD   = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(SOF_TIMEOUT - 1);
    localparam logic [3:0]     LAST_FRAME   = 4'(DISCARD_FRAMES - 1);
    localparam pipe_settings_t RESET_SETTINGS = '{mode: 1'b0, gaussian: 1'b0, sobel: 1'b0, threshold: THRESH_INIT};

    ctrl_state_t    state;
    logic [3:0]     frame_cnt;
    pipe_settings_t req;
    pipe_settings_t snapshot;
    pipe_settings_t applied;
    logic           mismatch;
    logic           discard_last;
    logic           pend_sof;
    logic           pend_timeout;
    logic           to_flush;
    logic           to_pending;
    logic           tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic           tmr_done;

    assign req = '{mode: i_req_mode, gaussian: i_req_gaussian, sobel: i_req_sobel, threshold: i_req_threshold};
    assign mismatch = (req != applied);

    // Transition decode shared by the FSM and the timer load, so the timer starts on the same edge as the state
    always_comb begin
        discard_last = 1'b0;
        pend_sof     = 1'b0;
        pend_timeout = 1'b0;
        to_flush     = 1'b0;
        to_pending   = 1'b0;
        tmr_load     = 1'b0;
        tmr_value    = TIMEOUT_LOAD;
        discard_last = (state == DISCARD) && i_sof && (frame_cnt == LAST_FRAME);
        pend_sof     = (state == PENDING) && i_sof;
        pend_timeout = (state == PENDING) && !i_sof && mismatch && tmr_done;
        to_flush     = discard_last || pend_sof || pend_timeout;
        to_pending   = (state == RUN) && !i_freeze && mismatch;
        tmr_load     = to_flush || to_pending;
        tmr_value    = to_flush ? FLUSH_LOAD : TIMEOUT_LOAD;
    end

    cycle_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk       (i_sysclk),
        .resetn    (i_rstn),
        .load      (tmr_load),
        .load_value(tmr_value),
        .done      (tmr_done)
    );

    // Sequencer FSM with registered outputs; applied settings change only on the APPLY exit edge
    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            state         <= CFG_START;
            frame_cnt     <= '0;
            snapshot      <= RESET_SETTINGS;
            applied       <= RESET_SETTINGS;
            o_pipe_flush  <= 1'b1;
            o_busy        <= 1'b1;
            o_cfg_start   <= 1'b0;
            o_sof_timeout <= 1'b0;
        end else begin
            o_cfg_start <= 1'b0;
            case (state)
                CFG_START: begin
                    o_cfg_start <= 1'b1;
                    state       <= CFG_WAIT;
                end
                CFG_WAIT: begin
                    if (i_cfg_done) begin
                        frame_cnt <= '0;
                        state     <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (discard_last) begin
                        snapshot <= req;
                        state    <= FLUSH;
                    end else if (i_sof) begin
                        frame_cnt <= frame_cnt + 4'd1;
                    end
                end
                RUN: begin
                    o_pipe_flush <= i_freeze;
                    if (to_pending) begin
                        o_busy <= 1'b1;
                        state  <= PENDING;
                    end
                end
                PENDING: begin
                    if (to_flush) begin
                        snapshot     <= req;
                        o_pipe_flush <= 1'b1;
                        state        <= FLUSH;
                        if (pend_timeout) begin
                            o_sof_timeout <= 1'b1;
                        end
                    end else if (!mismatch) begin
                        o_pipe_flush <= i_freeze;
                        o_busy       <= 1'b0;
                        state        <= RUN;
                    end
                end
                FLUSH: begin
                    if (tmr_done) begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    applied      <= snapshot;
                    o_pipe_flush <= i_freeze;
                    o_busy       <= 1'b0;
                    state        <= RUN;
                end
                default: begin
                    state <= CFG_START;
                end
            endcase
        end
    end

    assign o_mode            = applied.mode;
    assign o_gaussian_enable = applied.gaussian;
    assign o_sobel_enable    = applied.sobel;
    assign o_sobel_threshold = applied.threshold;

endmodule

// File: tb/tb_pipe_reconfig_ctrl.sv
// tb/tb_pipe_reconfig_ctrl.sv - directed self-checking bench for pipe_reconfig_ctrl
module tb_pipe_reconfig_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sof;
    logic        cfg_done;
    logic        freeze;
    logic        req_mode;
    logic        req_gaussian;
    logic        req_sobel;
    logic [25:0] req_threshold;
    logic        cfg_start;
    logic        mode;
    logic        gaussian_enable;
    logic        sobel_enable;
    logic [25:0] sobel_threshold;
    logic        pipe_flush;
    logic        busy;
    logic        sof_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int cfg_cnt = 0;
    int cfg_last = -1;
    int bring_first_low = 0;
    int fl_cnt = 0;
    int fl_first = -1;
    int fl_last = -1;
    int rv_flush = 0;
    int rv_gauss = 0;
    int freeze_err = 0;
    logic prev_freeze;

    pipe_reconfig_ctrl #(
        .FLUSH_CYCLES  (16),
        .DISCARD_FRAMES(2),
        .SOF_TIMEOUT   (50),
        .THRESH_INIT   (26'd4000)
    ) dut (
        .i_sysclk         (clk),
        .i_rstn           (rstn),
        .i_sof            (sof),
        .i_cfg_done       (cfg_done),
        .i_freeze         (freeze),
        .i_req_mode       (req_mode),
        .i_req_gaussian   (req_gaussian),
        .i_req_sobel      (req_sobel),
        .i_req_threshold  (req_threshold),
        .o_cfg_start      (cfg_start),
        .o_mode           (mode),
        .o_gaussian_enable(gaussian_enable),
        .o_sobel_enable   (sobel_enable),
        .o_sobel_threshold(sobel_threshold),
        .o_pipe_flush     (pipe_flush),
        .o_busy           (busy),
        .o_sof_timeout    (sof_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_flush"},     32'(pipe_flush),      32'd1);
        check({pfx, "_busy"},      32'(busy),            32'd1);
        check({pfx, "_cfg_start"}, 32'(cfg_start),       32'd0);
        check({pfx, "_timeout"},   32'(sof_timeout),     32'd0);
        check({pfx, "_mode"},      32'(mode),            32'd0);
        check({pfx, "_gauss"},     32'(gaussian_enable), 32'd0);
        check({pfx, "_sobel"},     32'(sobel_enable),    32'd0);
        check({pfx, "_thresh"},    32'(sobel_threshold), 32'd4000);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Inputs for the current cycle; they are sampled on the edge that ends it
    task automatic drive();
        sof = (cyc == 200) || (cyc == 300) || (cyc == 1030) || (cyc == 1450) ||
              (cyc == 1850) || (cyc == 1900) || (cyc == 1980) || (cyc == 2110);
        case (cyc)
            0:    rstn          = 1'b1;
            100:  cfg_done      = 1'b1;
            500:  cfg_done      = 1'b0;
            1000: req_mode      = 1'b1;
            1200: req_gaussian  = 1'b0;
            1210: req_gaussian  = 1'b1;
            1400: req_gaussian  = 1'b0;
            1600: req_threshold = 26'd9000;
            1800: freeze        = 1'b1;
            1810: req_sobel     = 1'b0;
            1950: freeze        = 1'b0;
            2100: req_mode      = 1'b0;
            2115: rstn          = 1'b0;
            2120: rstn          = 1'b1;
            default: ;
        endcase
    endtask

    task automatic observe();
        if (cfg_start) begin
            cfg_cnt++;
            cfg_last = cyc;
        end
        if (!pipe_flush && bring_first_low == 0 && cyc < 1000) bring_first_low = cyc;
        if (cyc >= 1001 && cyc <= 1100 && pipe_flush) begin
            fl_cnt++;
            if (fl_first < 0) fl_first = cyc;
            fl_last = cyc;
        end
        if (cyc >= 1100 && cyc <= 1399) begin
            if (pipe_flush) rv_flush++;
            if (gaussian_enable !== 1'b1) rv_gauss++;
        end
        if (cyc >= 1801 && cyc <= 1975 && pipe_flush !== prev_freeze) freeze_err++;
        case (cyc)
            317: begin
                check("bringup_apply_flush", 32'(pipe_flush), 32'd1);
                check("bringup_apply_gauss_old", 32'(gaussian_enable), 32'd0);
            end
            318: begin
                check("bringup_busy", 32'(busy), 32'd0);
                check("bringup_gauss", 32'(gaussian_enable), 32'd1);
                check("bringup_sobel", 32'(sobel_enable), 32'd1);
                check("bringup_mode", 32'(mode), 32'd0);
                check("bringup_thresh", 32'(sobel_threshold), 32'd4000);
            end
            400:  check("bringup_first_flush_low", 32'(bring_first_low), 32'd318);
            1047: check("mode_before_apply", 32'(mode), 32'd0);
            1048: begin
                check("mode_applied", 32'(mode), 32'd1);
                check("mode_flush_off", 32'(pipe_flush), 32'd0);
            end
            1100: begin
                check("mode_flush_count", 32'(fl_cnt), 32'd17);
                check("mode_flush_first", 32'(fl_first), 32'd1031);
                check("mode_flush_last", 32'(fl_last), 32'd1047);
                check("mode_no_timeout", 32'(sof_timeout), 32'd0);
                check("cfg_start_count", 32'(cfg_cnt), 32'd1);
                check("cfg_start_cycle", 32'(cfg_last), 32'd1);
            end
            1205: begin
                check("revert_pending_busy", 32'(busy), 32'd1);
                check("revert_pending_flush", 32'(pipe_flush), 32'd0);
            end
            1212: check("revert_run_busy", 32'(busy), 32'd0);
            1399: begin
                check("revert_no_flush", 32'(rv_flush), 32'd0);
                check("revert_gauss_held", 32'(rv_gauss), 32'd0);
            end
            1467: check("tie_gauss_before_apply", 32'(gaussian_enable), 32'd1);
            1468: begin
                check("tie_gauss_applied", 32'(gaussian_enable), 32'd0);
                check("tie_sof_wins", 32'(sof_timeout), 32'd0);
                check("tie_flush_off", 32'(pipe_flush), 32'd0);
            end
            1650: check("timeout_not_yet", 32'(sof_timeout), 32'd0);
            1651: begin
                check("timeout_flag", 32'(sof_timeout), 32'd1);
                check("timeout_flush", 32'(pipe_flush), 32'd1);
            end
            1667: check("timeout_thresh_old", 32'(sobel_threshold), 32'd4000);
            1668: begin
                check("timeout_thresh_new", 32'(sobel_threshold), 32'd9000);
                check("timeout_flush_off", 32'(pipe_flush), 32'd0);
                check("timeout_busy", 32'(busy), 32'd0);
            end
            1940: begin
                check("freeze_busy", 32'(busy), 32'd0);
                check("freeze_sobel_held", 32'(sobel_enable), 32'd1);
            end
            1976: check("freeze_flush_mirror", 32'(freeze_err), 32'd0);
            1997: check("unfreeze_sobel_old", 32'(sobel_enable), 32'd1);
            1998: begin
                check("unfreeze_sobel_new", 32'(sobel_enable), 32'd0);
                check("unfreeze_flush_off", 32'(pipe_flush), 32'd0);
            end
            2116: check_reset_outputs("midreset");
            2140: begin
                check("midreset_cfg_start_count", 32'(cfg_cnt), 32'd2);
                check("midreset_cfg_start_cycle", 32'(cfg_last), 32'd2121);
            end
            default: ;
        endcase
    endtask

    initial begin
        rstn          = 1'b0;
        sof           = 1'b0;
        cfg_done      = 1'b0;
        freeze        = 1'b0;
        req_mode      = 1'b0;
        req_gaussian  = 1'b1;
        req_sobel     = 1'b1;
        req_threshold = 26'd4000;
        prev_freeze   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        cyc = 0;
        while (cyc < 2150) begin
            drive();
            prev_freeze = freeze;
            step();
            observe();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_reconfig_ctrl.md
# pipe_reconfig_ctrl

Frame-synchronous sequencer for the `i_sysclk` video pipeline (preprocess → gaussian → sobel → mem_interface). It runs the power-up bring-up: camera configuration, then discarding the first frames. After bring-up it defers every operator setting change to a start-of-frame boundary, flushes the pipeline around that change, and only then presents the new settings. Downstream stages therefore never see a frame processed with mixed settings. It sits between `sys_control`'s raw setting outputs and the pipeline stages, and drives the shared flush line.

## Interface
Parameters:
- `FLUSH_CYCLES`, 16: cycles `o_pipe_flush` is held per reconfiguration (≥2).
- `DISCARD_FRAMES`, 2: SOFs discarded after camera configuration completes (1–15).
- `SOF_TIMEOUT`, 2_500_000: cycles to wait for an SOF before forcing the change (20 ms at 125 MHz).
- `THRESH_INIT`, 26'd4000: reset value of `o_sobel_threshold`.

Ports:
- `i_sysclk`, in, 1: 125 MHz clock. One clock; reset is synchronous and active-low.
- `i_rstn`, in, 1: synchronous active-low reset.
- `i_sof`, in, 1: single-cycle start-of-frame pulse from `cam_top`.
- `i_cfg_done`, in, 1: camera configuration complete (level).
- `i_freeze`, in, 1: freeze switch, already synchronised.
- `i_req_mode`, `i_req_gaussian`, `i_req_sobel`, in, 1 each: requested settings.
- `i_req_threshold`, in, 26: requested sobel threshold.
- `o_cfg_start`, out, 1: single-cycle camera configuration start pulse.
- `o_mode`, `o_gaussian_enable`, `o_sobel_enable`, out, 1 each: applied settings.
- `o_sobel_threshold`, out, 26: applied threshold.
- `o_pipe_flush`, out, 1: pipeline flush.
- `o_busy`, out, 1: high in every state except `RUN`.
- `o_sof_timeout`, out, 1: sticky flag, set when a change was forced without an SOF.

## Operation
States: `CFG_START`, `CFG_WAIT`, `DISCARD`, `RUN`, `PENDING`, `FLUSH`, `APPLY`.

Reset values:
- state = `CFG_START`
- `o_pipe_flush` = 1, `o_busy` = 1
- `o_cfg_start` = 0, `o_sof_timeout` = 0
- `o_mode`, `o_gaussian_enable`, `o_sobel_enable` = 0
- `o_sobel_threshold` = `THRESH_INIT`

State behaviour:
- `CFG_START`: `o_cfg_start` = 1 for exactly one cycle, then go to `CFG_WAIT`.
- `CFG_WAIT`: wait for `i_cfg_done` = 1, then go to `DISCARD` with the frame counter cleared.
- `DISCARD`: count SOFs. On the `DISCARD_FRAMES`-th SOF, snapshot the request inputs and go to `FLUSH`. This first application is the bring-up change, so the applied settings match the requests from the start.
- `RUN`: `o_pipe_flush` = `i_freeze`. A change is any mismatch between the requested settings (mode, gaussian, sobel, threshold) and the applied outputs. A change goes to `PENDING` on the next edge. The mismatch is not evaluated while `i_freeze` = 1; the change is deferred and stays pending until freeze drops.
- `PENDING`: timeout counter runs.
  - On `i_sof`: snapshot all requests on that edge, go to `FLUSH`.
  - If the counter reaches `SOF_TIMEOUT` first: snapshot, set `o_sof_timeout`, go to `FLUSH`.
  - If the mismatch disappears before an SOF (request reverted): return to `RUN`, with no flush.
- `FLUSH`: `o_pipe_flush` = 1 for `FLUSH_CYCLES` cycles, then go to `APPLY`.
- `APPLY`: one cycle with `o_pipe_flush` = 1. The outputs load the snapshot on the exit edge, then go to `RUN`.

Width rules:
- Threshold compare and load use the full 26 bits; no truncation.
- Cycle counter is `$clog2(max(FLUSH_CYCLES, SOF_TIMEOUT)+1)` bits.
- Frame counter is 4 bits.

Boundary conditions:
- Requests that change during `FLUSH` or `APPLY` are ignored until `RUN`. The mismatch is then re-evaluated, which gives a second reconfiguration.
- An SOF in `FLUSH`, `APPLY`, or `RUN` is ignored.
- If an SOF and the timeout occur on the same cycle, the SOF wins and `o_sof_timeout` is not set.
- `i_rstn` low in any state restarts the sequence from `CFG_START`, including a new `o_cfg_start` pulse.
- `i_cfg_done` dropping after `CFG_WAIT` has no effect.

## Timing
- SOF sampled in `PENDING` at edge N:
  - `o_pipe_flush` = 1 from cycle N+1 through N+1+`FLUSH_CYCLES` (the last cycle is `APPLY`).
  - New settings are visible from cycle N+2+`FLUSH_CYCLES`, the same cycle flush deasserts.
- A request change is detected at edge M, giving `PENDING` at M+1. An SOF arriving on M+1 is taken.
- All outputs are registered. There are no combinational input-to-output paths except `o_pipe_flush` = `i_freeze` in `RUN`. That path is registered too: `o_pipe_flush` follows `i_freeze` with a 1-cycle delay.
- `o_cfg_start` is high in exactly one cycle per reset release: cycle 1 after `i_rstn` goes high.

## Structure
- A shared package `pipe_ctrl_pkg` holds the state enumeration and the bundled settings typedef (mode, gaussian, sobel, threshold[25:0]). `sys_control` and this block share that typedef.
- One natural sub-module, `cycle_timer`: a loadable down-counter with a done flag. It is reused for the `FLUSH_CYCLES` count and the `SOF_TIMEOUT` count.
- The rest is one FSM plus the snapshot and applied registers.

## Test plan
- **Reset bring-up:** release `i_rstn`; `i_cfg_done` at cycle 100; SOFs at cycles 200, 300 (`DISCARD_FRAMES`=2).
  - Required: `o_cfg_start` high only in cycle 1.
  - Required: flush high continuously until cycle 300+17.
  - Required: `o_busy` = 0 afterwards.
- **Mode change:** in `RUN`, toggle `i_req_mode` at cycle 1000; SOF at 1500.
  - Required: `o_mode` unchanged until 1500+18.
  - Required: flush high exactly cycles 1501–1517.
- **Reverted request:** toggle `i_req_gaussian` and toggle it back before any SOF.
  - Required: return to `RUN`, no flush pulse, outputs unchanged.
- **Missing SOF:** request a threshold change from 4000 to 9000 with no SOF; shorten `SOF_TIMEOUT` to 50 in the bench.
  - Required: forced flush, `o_sof_timeout` = 1, `o_sobel_threshold` = 9000.
  - Also required: SOF and timeout on the same cycle → `o_sof_timeout` stays 0.
- **Freeze:** hold `i_freeze`; change `i_req_sobel`; SOFs pass.
  - Required: flush mirrors freeze and no apply occurs.
  - Required: release freeze, then the next SOF applies the change.
- **Reset mid-operation:** assert `i_rstn` low during `FLUSH`.
  - Required: all outputs return to their reset values.
  - Required: `o_cfg_start` pulses again on release.
